acquisition_sequencer: RTL

//   Sequences ADC capture into the sample RAM for the analog acquisition tool. After an MCU arm

---
 rtl/acquisition_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/acquisition_sequencer.sv
// Acquisition sequencer: steers decimated ADC samples into the sample RAM,
// covering a pre-trigger window, a circular wait-for-trigger phase and a
// post-trigger window, then freezes the buffer and raises ready.
module acquisition_sequencer #(
  parameter int AddrWidth = 12,
  parameter int DataWidth = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 trigger,
  input  logic [7:0]           decim,
  input  logic [AddrWidth-1:0] pre_count,
  input  logic [DataWidth-1:0] sample_in,
  output logic                 wr_en,
  output logic [AddrWidth-1:0] wr_addr,
  output logic [DataWidth-1:0] wr_data,
  output logic                 ready,
  output logic                 busy,
  output logic [AddrWidth-1:0] trig_addr,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Buffer depth expressed in the counter width (one bit wider than an address)
  localparam logic [AddrWidth:0] DepthW = {1'b1, {AddrWidth{1'b0}}};

  state_t                 state_q, state_d;
  logic                   trig_s1_q, trig_s2_q, trig_prev_q;
  logic [7:0]             div_cnt_q, div_cnt_d;
  logic [AddrWidth-1:0]   ptr_q, ptr_d;
  logic [AddrWidth:0]     cnt_q, cnt_d;
  logic [AddrWidth-1:0]   pre_lat_q, pre_lat_d;
  logic                   wr_en_q, wr_en_d;
  logic [AddrWidth-1:0]   wr_addr_q, wr_addr_d;
  logic [DataWidth-1:0]   wr_data_q, wr_data_d;
  logic                   ready_q, ready_d;
  logic [AddrWidth-1:0]   trig_addr_q, trig_addr_d;

  logic                   busy_w;
  logic                   tick;
  logic                   trig_evt;
  logic [AddrWidth-1:0]   ptr_inc;
  logic [AddrWidth:0]     cnt_inc;
  logic [AddrWidth:0]     post_len;

  assign busy_w   = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign tick     = busy_w && (div_cnt_q == decim);
  assign trig_evt = trig_s2_q & ~trig_prev_q;
  assign ptr_inc  = ptr_q + AddrWidth'(1);
  assign cnt_inc  = cnt_q + (AddrWidth + 1)'(1);
  // Post window fills the rest of the ring after the pre-trigger samples
  assign post_len = DepthW - {1'b0, pre_lat_q};

  // Trigger pin synchronizer plus previous-value flop for rising-edge detection
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      trig_s1_q   <= 1'b0;
      trig_s2_q   <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      trig_s1_q   <= trigger;
      trig_s2_q   <= trig_s1_q;
      trig_prev_q <= trig_s2_q;
    end
  end

  // Next-state, counters and write-port computation; abort beats arm beats state logic
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = busy_w ? ((div_cnt_q >= decim) ? 8'd0 : div_cnt_q + 8'd1) : 8'd0;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    pre_lat_d   = pre_lat_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    ready_d     = ready_q;
    trig_addr_d = trig_addr_q;

    if (abort) begin
      state_d   = S_IDLE;
      ready_d   = 1'b0;
      div_cnt_d = 8'd0;
    end else if (arm) begin
      // pre_count cannot exceed Depth-1 at this port width, so no explicit clamp is needed
      state_d   = (pre_count == '0) ? S_WAIT : S_PRE;
      ptr_d     = '0;
      cnt_d     = '0;
      pre_lat_d = pre_count;
      ready_d   = 1'b0;
      div_cnt_d = 8'd0;
    end else begin
      if (tick) begin
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q;
        wr_data_d = sample_in;
        ptr_d     = ptr_inc;
      end
      case (state_q)
        S_PRE: begin
          // Trigger events are deliberately ignored until the pre window is full
          if (tick) begin
            cnt_d = cnt_inc;
            if (cnt_inc == {1'b0, pre_lat_q}) state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (trig_evt) begin
            // A coincident tick's sample is the last pre-trigger sample
            trig_addr_d = tick ? ptr_inc : ptr_q;
            cnt_d       = '0;
            state_d     = S_POST;
          end
        end
        S_POST: begin
          if (tick) begin
            cnt_d = cnt_inc;
            if (cnt_inc == post_len) begin
              state_d = S_DONE;
              ready_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State, counter and write-port registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      pre_lat_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      ready_q     <= 1'b0;
      trig_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      pre_lat_q   <= pre_lat_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      ready_q     <= ready_d;
      trig_addr_q <= trig_addr_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign ready     = ready_q;
  assign busy      = busy_w;
  assign trig_addr = trig_addr_q;
  assign state     = state_q;

endmodule
